pe_array_feeder: RTL and testbench

//  Transmit side of the PE operand interface. Buffers one A tile (N rows x K) and one B tile (N cols x K).
//  On start, streams both tiles into the edge of an NxN systolic PE array with the diagonal skew the array needs.

---
 rtl/pe_feeder_pkg.sv | 21 ++
 rtl/pe_array_feeder_if.sv | 45 ++++
 rtl/pe_feeder_buf.sv | 45 ++++
 rtl/pe_array_feeder.sv | 168 ++++++++++++++++
 tb/tb_pe_array_feeder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE array feeder.
// Optional stall counter is enabled with `FEEDER_STALL_CNT_EN.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_e;

  localparam int DEFAULT_DW = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Index width that stays legal when a dimension collapses to 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_array_feeder_if.sv
// Host/array facing bus of the feeder: buffer write port, start, and skewed lane outputs.
// stall_cnt exists only with `FEEDER_STALL_CNT_EN.
interface pe_array_feeder_if #(
  parameter int N  = 4,
  parameter int K  = 8,
  parameter int DW = 16
);
  localparam int LW = pe_feeder_pkg::idx_w(N);
  localparam int KW = pe_feeder_pkg::idx_w(K);

  logic            wr_en;
  logic            wr_sel;
  logic [LW-1:0]   wr_lane;
  logic [KW-1:0]   wr_k;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            arr_rdy;
  logic [N*DW-1:0] a_out;
  logic [N-1:0]    a_val;
  logic [N*DW-1:0] b_out;
  logic [N-1:0]    b_val;
  logic            busy;
  logic            done;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]     stall_cnt;

  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_k, wr_data, start, arr_rdy,
    output a_out, a_val, b_out, b_val, busy, done, stall_cnt
  );
  modport master (
    output wr_en, wr_sel, wr_lane, wr_k, wr_data, start, arr_rdy,
    input  a_out, a_val, b_out, b_val, busy, done, stall_cnt
  );
`else
  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_k, wr_data, start, arr_rdy,
    output a_out, a_val, b_out, b_val, busy, done
  );
  modport master (
    output wr_en, wr_sel, wr_lane, wr_k, wr_data, start, arr_rdy,
    input  a_out, a_val, b_out, b_val, busy, done
  );
`endif
endinterface

// File: rtl/pe_feeder_buf.sv
// N x K operand tile store: one write port, N combinational skewed read ports.
// Lane gi reads element rd_t-gi; outside the tile window it returns 0 / valid 0.
module pe_feeder_buf
  import pe_feeder_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 8,
  parameter int DW = DEFAULT_DW,
  parameter int LW = idx_w(N),
  parameter int KW = idx_w(K),
  parameter int TW = $clog2(K + N)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [LW-1:0]   wr_lane,
  input  logic [KW-1:0]   wr_k,
  input  logic [DW-1:0]   wr_data,
  input  logic [TW-1:0]   rd_t,
  output logic [N*DW-1:0] rd_data,
  output logic [N-1:0]    rd_val
);

  logic [DW-1:0] mem_q [N][K];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_lane][wr_k] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [TW-1:0] LANE = TW'(gi);
      logic [TW-1:0] rel;
      logic          in_win;

      assign rel    = rd_t - LANE;
      assign in_win = (rd_t >= LANE) && (rel < TW'(K));
      assign rd_val[gi]             = in_win;
      assign rd_data[gi*DW +: DW]   = in_win ? mem_q[gi][rel[KW-1:0]] : '0;
    end
  endgenerate

endmodule

// File: rtl/pe_array_feeder.sv
// Streams buffered A/B tiles into an NxN systolic array with per-lane diagonal skew.
// `FEEDER_STALL_CNT_EN adds a saturating count of stalled stream cycles.
module pe_array_feeder
  import pe_feeder_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 8,
  parameter int DW = DEFAULT_DW
) (
  input  logic clk,
  input  logic reset,
  pe_array_feeder_if.slave bus
);

  localparam int LW = idx_w(N);
  localparam int KW = idx_w(K);
  localparam int TW = $clog2(K + N);
  localparam logic [TW-1:0] LAST_BEAT = TW'(K + N - 2);

  feeder_state_e   state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [N*DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic [N-1:0]    a_val_q, a_val_d, b_val_q, b_val_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;

  logic [N*DW-1:0] a_rd_data, b_rd_data;
  logic [N-1:0]    a_rd_val, b_rd_val;

  logic start_acc;
  logic wr_ok;

  assign start_acc = (state_q == ST_IDLE) && bus.start;
  // The start cycle drops writes so the beat-0 read cannot race a buffer update.
  assign wr_ok = bus.wr_en && (state_q != ST_STREAM) && !start_acc
              && (32'(bus.wr_lane) < N) && (32'(bus.wr_k) < K);

  pe_feeder_buf #(.N(N), .K(K), .DW(DW), .LW(LW), .KW(KW), .TW(TW)) u_buf_a (
    .clk     (clk),
    .wr_en   (wr_ok && (bus.wr_sel == SEL_A)),
    .wr_lane (bus.wr_lane),
    .wr_k    (bus.wr_k),
    .wr_data (bus.wr_data),
    .rd_t    (t_d),
    .rd_data (a_rd_data),
    .rd_val  (a_rd_val)
  );

  pe_feeder_buf #(.N(N), .K(K), .DW(DW), .LW(LW), .KW(KW), .TW(TW)) u_buf_b (
    .clk     (clk),
    .wr_en   (wr_ok && (bus.wr_sel == SEL_B)),
    .wr_lane (bus.wr_lane),
    .wr_k    (bus.wr_k),
    .wr_data (bus.wr_data),
    .rd_t    (t_d),
    .rd_data (b_rd_data),
    .rd_val  (b_rd_val)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_STREAM;
          t_d     = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_STREAM: begin
        if (bus.arr_rdy) begin
          if (t_q == LAST_BEAT) begin
            state_d = ST_DONE;
            t_d     = '0;
            a_out_d = '0;
            b_out_d = '0;
            a_val_d = '0;
            b_val_d = '0;
            done_d  = 1'b1;
          end else begin
            t_d  = t_q + 1'b1;
            load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Buffers are addressed by t_d, so the beat being entered is what gets captured.
    if (load) begin
      a_out_d = a_rd_data;
      b_out_d = b_rd_data;
      a_val_d = a_rd_val;
      b_val_d = b_rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      a_val_q <= '0;
      b_val_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      a_val_q <= a_val_d;
      b_val_q <= b_val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_out = a_out_q;
  assign bus.b_out = b_out_q;
  assign bus.a_val = a_val_q;
  assign bus.b_val = b_val_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_STREAM) && !bus.arr_rdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder (N=4, K=8, DW=16); stall checks need `FEEDER_STALL_CNT_EN.
module tb_pe_array_feeder;

  localparam int N  = 4;
  localparam int K  = 8;
  localparam int DW = 16;

  logic clk;
  logic reset;

  pe_array_feeder_if #(.N(N), .K(K), .DW(DW)) bus ();

  pe_array_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          beat;
    logic [3:0]  a_val;
    logic [3:0]  b_val;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a3;
    logic [15:0] b0;
    logic [15:0] b3;
  } beat_vec_t;

  beat_vec_t tbl [7];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  int s_cyc    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  function automatic logic [15:0] a_lane(input int i);
    return bus.a_out[i*DW +: DW];
  endfunction

  function automatic logic [15:0] b_lane(input int i);
    return bus.b_out[i*DW +: DW];
  endfunction

  task automatic check_vec(input beat_vec_t v, input string tag);
    chk($sformatf("%s beat%0d a_val", tag, v.beat), 32'(bus.a_val), 32'(v.a_val));
    chk($sformatf("%s beat%0d b_val", tag, v.beat), 32'(bus.b_val), 32'(v.b_val));
    chk($sformatf("%s beat%0d a0", tag, v.beat), 32'(a_lane(0)), 32'(v.a0));
    chk($sformatf("%s beat%0d a1", tag, v.beat), 32'(a_lane(1)), 32'(v.a1));
    chk($sformatf("%s beat%0d a3", tag, v.beat), 32'(a_lane(3)), 32'(v.a3));
    chk($sformatf("%s beat%0d b0", tag, v.beat), 32'(b_lane(0)), 32'(v.b0));
    chk($sformatf("%s beat%0d b3", tag, v.beat), 32'(b_lane(3)), 32'(v.b3));
  endtask

  task automatic write_elem(input logic sel, input int lane, input int k, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_lane = 2'(lane);
    bus.wr_k    = 3'(k);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        write_elem(1'b0, i, k, 16'(16 * i + k));
        write_elem(1'b1, i, k, 16'(16'h100 + 16 * i + k));
      end
  endtask

  task automatic do_start();
    s_cyc     = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, checks its cycle offset from start, then its one-cycle width.
  task automatic wait_done(input string tag, input int exp_lat);
    int budget = 0;
    while (!bus.done && budget < 200) begin
      tick();
      budget++;
    end
    chk($sformatf("%s done latency", tag), 32'(cyc - s_cyc), 32'(exp_lat));
    chk($sformatf("%s busy at done", tag), 32'(bus.busy), 32'd1);
    tick();
    chk($sformatf("%s done pulse width", tag), 32'(bus.done), 32'd0);
    chk($sformatf("%s busy after done", tag), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int done_seen;

    tbl[0] = '{0,  4'b0001, 4'b0001, 16'h00, 16'h00, 16'h00, 16'h100, 16'h000};
    tbl[1] = '{1,  4'b0011, 4'b0011, 16'h01, 16'h10, 16'h00, 16'h101, 16'h000};
    tbl[2] = '{3,  4'b1111, 4'b1111, 16'h03, 16'h12, 16'h30, 16'h103, 16'h130};
    tbl[3] = '{5,  4'b1111, 4'b1111, 16'h05, 16'h14, 16'h32, 16'h105, 16'h132};
    tbl[4] = '{7,  4'b1111, 4'b1111, 16'h07, 16'h16, 16'h34, 16'h107, 16'h134};
    tbl[5] = '{8,  4'b1110, 4'b1110, 16'h00, 16'h17, 16'h35, 16'h000, 16'h135};
    tbl[6] = '{10, 4'b1000, 4'b1000, 16'h00, 16'h00, 16'h37, 16'h000, 16'h137};

    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_lane = '0;
    bus.wr_k    = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.arr_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset a_val", 32'(bus.a_val), 32'd0);
    chk("reset b_val", 32'(bus.b_val), 32'd0);
    chk("reset a_out", bus.a_out[31:0] | bus.a_out[63:32], 32'd0);
    chk("reset b_out", bus.b_out[31:0] | bus.b_out[63:32], 32'd0);
`ifdef FEEDER_STALL_CNT_EN
    chk("reset stall_cnt", bus.stall_cnt, 32'd0);
`endif

    fill();

    // 1: free-running stream
    do_start();
    for (int b = 0; b < K + N - 1; b++) begin
      for (int e = 0; e < 7; e++)
        if (tbl[e].beat == b) check_vec(tbl[e], "t1");
      chk($sformatf("t1 beat%0d no early done", b), 32'(bus.done), 32'd0);
      tick();
    end
    wait_done("t1", 12);
`ifdef FEEDER_STALL_CNT_EN
    chk("t1 stall_cnt", bus.stall_cnt, 32'd0);
`endif

    // 2: three stalled cycles while beat 5 is shown
    do_start();
    for (int b = 0; b < 5; b++) tick();
    bus.arr_rdy = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check_vec(tbl[3], $sformatf("t2 hold%0d", h));
      tick();
    end
    bus.arr_rdy = 1'b1;
    check_vec(tbl[3], "t2 hold3");
    tick();
    chk("t2 beat6 a0", 32'(a_lane(0)), 32'h06);
    wait_done("t2", 15);
`ifdef FEEDER_STALL_CNT_EN
    chk("t2 stall_cnt", bus.stall_cnt, 32'd3);
    tick();
    chk("t2 stall_cnt holds", bus.stall_cnt, 32'd3);
`endif

    // 3: start and write while streaming are both ignored
    do_start();
    tick();
    tick();
    bus.start = 1'b1;
    write_elem(1'b0, 0, 0, 16'hFFFF);
    bus.start = 1'b0;
    check_vec(tbl[2], "t3 no restart");
    wait_done("t3", 12);
    do_start();
    chk("t3 rerun beat0 a0", 32'(a_lane(0)), 32'h00);
    wait_done("t3 rerun", 12);

    // 4: reset while beat 4 is shown
    do_start();
    for (int b = 0; b < 4; b++) tick();
    chk("t4 beat4 a0", 32'(a_lane(0)), 32'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4 busy", 32'(bus.busy), 32'd0);
    chk("t4 a_val", 32'(bus.a_val), 32'd0);
    chk("t4 b_val", 32'(bus.b_val), 32'd0);
    chk("t4 a_out", bus.a_out[31:0] | bus.a_out[63:32], 32'd0);
    done_seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) done_seen++;
      tick();
    end
    chk("t4 no done after abort", 32'(done_seen), 32'd0);
    do_start();
    check_vec(tbl[0], "t4 replay");
    wait_done("t4 replay", 12);

    // 5: write in the start cycle is dropped
    bus.start = 1'b1;
    s_cyc     = cyc;
    write_elem(1'b0, 1, 0, 16'hABCD);
    bus.start = 1'b0;
    check_vec(tbl[0], "t5");
    tick();
    chk("t5 beat1 a1", 32'(a_lane(1)), 32'h10);
    wait_done("t5", 12);

    // 6: array not ready for the first five stream cycles
    bus.arr_rdy = 1'b0;
    do_start();
    for (int h = 0; h < 5; h++) begin
      check_vec(tbl[0], $sformatf("t6 hold%0d", h));
      tick();
    end
    bus.arr_rdy = 1'b1;
    check_vec(tbl[0], "t6 hold5");
    tick();
    check_vec(tbl[1], "t6");
    wait_done("t6", 17);
`ifdef FEEDER_STALL_CNT_EN
    chk("t6 stall_cnt", bus.stall_cnt, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
